// File: rtl/sd_block_responder_pkg.sv
// Shared constants for the SD block responder: block geometry and FSM state encoding.
package sd_resp_pkg;

    localparam int unsigned BLK_BYTES = 512;
    localparam int unsigned IDX_W     = 9;
    localparam logic [IDX_W-1:0] LAST_IDX = 9'd511;

    localparam int unsigned ST_W = 3;
    localparam logic [ST_W-1:0] S_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] S_DELAY   = 3'd1;
    localparam logic [ST_W-1:0] S_RD_MEM  = 3'd2;
    localparam logic [ST_W-1:0] S_RD_BUF  = 3'd3;
    localparam logic [ST_W-1:0] S_WR_ADDR = 3'd4;
    localparam logic [ST_W-1:0] S_WR_CAP  = 3'd5;
    localparam logic [ST_W-1:0] S_WR_MEM  = 3'd6;
    localparam logic [ST_W-1:0] S_DONE    = 3'd7;

    // True on the final byte of a block; the index never wraps past it.
    function automatic logic is_last_idx(input logic [IDX_W-1:0] idx);
        return idx == LAST_IDX;
    endfunction

endpackage

// File: rtl/sd_block_responder_if.sv
// SD block protocol + backing-memory bus bundle. The wp_hit signal exists only
// when SD_RESP_WPROT_EN is defined.
interface sd_block_responder_if #(
    parameter int unsigned ADDR_W = 25
);
    import sd_resp_pkg::*;

    logic [31:0]       sd_lba;
    logic              sd_rd;
    logic              sd_wr;
    logic              sd_ack;
    logic [IDX_W-1:0]  sd_buff_addr;
    logic [7:0]        sd_buff_dout;
    logic              sd_buff_wr;
    logic [7:0]        sd_buff_din;
    logic [31:0]       img_blocks;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic              mem_ready;

    logic              busy;
    logic              range_err;
`ifdef SD_RESP_WPROT_EN
    logic              wp_hit;
`endif

    // Responder side
    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din, img_blocks, mem_dout, mem_ready,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        output mem_addr, mem_rd, mem_wr, mem_din, busy,
`ifdef SD_RESP_WPROT_EN
        output wp_hit,
`endif
        output range_err
    );

    // Initiator / memory side
    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din, img_blocks, mem_dout, mem_ready,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        input  mem_addr, mem_rd, mem_wr, mem_din, busy,
`ifdef SD_RESP_WPROT_EN
        input  wp_hit,
`endif
        input  range_err
    );

endinterface

// File: rtl/sd_block_responder.sv
// Device-side SD block responder: serves 512-byte reads/writes from a byte-wide memory.
// Define SD_RESP_WPROT_EN to make the image write-protected (writes acked, never stored).
module sd_block_responder
    import sd_resp_pkg::*;
#(
    parameter int unsigned ADDR_W    = 25,
    parameter int unsigned ACK_DELAY = 2
) (
    input  logic clk_sys,
    input  logic reset,
    sd_block_responder_if.slave bus
);

    localparam int unsigned LBA_W = ADDR_W - $clog2(BLK_BYTES);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(ACK_DELAY - 1);
    localparam bit SKIP_DELAY = (ACK_DELAY == 0);

    logic [ST_W-1:0]   r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic [LBA_W-1:0]  r_lba;
    logic              r_is_wr;
    logic              r_in_range;
    logic              r_range_err;
    logic              r_rd_d;
    logic              r_wr_d;
    logic              r_ack;
    logic              r_busy;
    logic [IDX_W-1:0]  r_buff_addr;
    logic [7:0]        r_buff_dout;
    logic              r_buff_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_rd;
    logic              r_mem_wr;
    logic [7:0]        r_mem_din;

    logic [ST_W-1:0]   w_nxt_state;
    logic [IDX_W-1:0]  w_nxt_idx;
    logic [CNT_W-1:0]  w_nxt_cnt;
    logic [LBA_W-1:0]  w_nxt_lba;
    logic              w_nxt_is_wr;
    logic              w_nxt_in_range;
    logic              w_nxt_range_err;
    logic [7:0]        w_nxt_buff_dout;
    logic [7:0]        w_nxt_mem_din;
    logic              w_nxt_ack;
    logic              w_nxt_busy;
    logic              w_nxt_mem_rd;
    logic              w_nxt_mem_wr;

    logic w_rd_rise;
    logic w_wr_rise;
    logic w_accept;
    logic w_req_in_range;
    logic w_wr_allow;

    assign w_rd_rise      = bus.sd_rd & ~r_rd_d;
    assign w_wr_rise      = bus.sd_wr & ~r_wr_d;
    assign w_accept       = (r_state == S_IDLE) & (w_rd_rise | w_wr_rise);
    assign w_req_in_range = bus.sd_lba < bus.img_blocks;

`ifdef SD_RESP_WPROT_EN
    logic r_wp_hit;
    assign w_wr_allow = 1'b0;
    assign bus.wp_hit = r_wp_hit;

    // Sticky flag: any write attempt against the protected image
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_wp_hit <= 1'b0;
        end else if (w_accept && !w_rd_rise) begin
            r_wp_hit <= 1'b1;
        end
    end
`else
    assign w_wr_allow = r_in_range;
`endif

    // Next-state and next-output logic
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_idx       = r_idx;
        w_nxt_cnt       = r_cnt;
        w_nxt_lba       = r_lba;
        w_nxt_is_wr     = r_is_wr;
        w_nxt_in_range  = r_in_range;
        w_nxt_range_err = r_range_err;
        w_nxt_buff_dout = r_buff_dout;
        w_nxt_mem_din   = r_mem_din;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    // Read wins when both edges land in the same cycle
                    w_nxt_lba       = LBA_W'(bus.sd_lba);
                    w_nxt_is_wr     = ~w_rd_rise;
                    w_nxt_in_range  = w_req_in_range;
                    w_nxt_range_err = ~w_req_in_range;
                    w_nxt_cnt       = '0;
                    if (SKIP_DELAY) begin
                        w_nxt_state = w_rd_rise ? S_RD_MEM : S_WR_ADDR;
                    end else begin
                        w_nxt_state = S_DELAY;
                    end
                end
            end
            S_DELAY: begin
                if (r_cnt == DLY_LAST) begin
                    w_nxt_state = r_is_wr ? S_WR_ADDR : S_RD_MEM;
                end else begin
                    w_nxt_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_RD_MEM: begin
                if (!r_in_range) begin
                    w_nxt_buff_dout = 8'h00;
                    w_nxt_state     = S_RD_BUF;
                end else if (bus.mem_ready) begin
                    w_nxt_buff_dout = bus.mem_dout;
                    w_nxt_state     = S_RD_BUF;
                end
            end
            S_RD_BUF: begin
                if (is_last_idx(r_idx)) begin
                    w_nxt_state = S_DONE;
                end else begin
                    w_nxt_idx   = r_idx + IDX_W'(1);
                    w_nxt_state = S_RD_MEM;
                end
            end
            S_WR_ADDR: begin
                w_nxt_state = S_WR_CAP;
            end
            S_WR_CAP: begin
                // Buffer RAM is registered: data for the address shown last cycle is valid now
                w_nxt_mem_din = bus.sd_buff_din;
                w_nxt_state   = S_WR_MEM;
            end
            S_WR_MEM: begin
                if (!w_wr_allow || bus.mem_ready) begin
                    if (is_last_idx(r_idx)) begin
                        w_nxt_state = S_DONE;
                    end else begin
                        w_nxt_idx   = r_idx + IDX_W'(1);
                        w_nxt_state = S_WR_ADDR;
                    end
                end
            end
            S_DONE: begin
                w_nxt_idx   = '0;
                w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase

        // Ack rises one cycle after accept and drops on entry to DONE
        w_nxt_ack    = (r_state != S_IDLE) && (w_nxt_state != S_DONE) && (w_nxt_state != S_IDLE);
        w_nxt_busy   = (w_nxt_state != S_IDLE);
        w_nxt_mem_rd = (w_nxt_state == S_RD_MEM) && w_nxt_in_range;
        w_nxt_mem_wr = (w_nxt_state == S_WR_MEM) && w_wr_allow;
    end

    // State and registered outputs
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_lba       <= '0;
            r_is_wr     <= 1'b0;
            r_in_range  <= 1'b0;
            r_range_err <= 1'b0;
            r_rd_d      <= 1'b0;
            r_wr_d      <= 1'b0;
            r_ack       <= 1'b0;
            r_busy      <= 1'b0;
            r_buff_addr <= '0;
            r_buff_dout <= '0;
            r_buff_wr   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_din   <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_idx       <= w_nxt_idx;
            r_cnt       <= w_nxt_cnt;
            r_lba       <= w_nxt_lba;
            r_is_wr     <= w_nxt_is_wr;
            r_in_range  <= w_nxt_in_range;
            r_range_err <= w_nxt_range_err;
            r_rd_d      <= bus.sd_rd;
            r_wr_d      <= bus.sd_wr;
            r_ack       <= w_nxt_ack;
            r_busy      <= w_nxt_busy;
            r_buff_addr <= w_nxt_idx;
            r_buff_dout <= w_nxt_buff_dout;
            r_buff_wr   <= (w_nxt_state == S_RD_BUF);
            r_mem_addr  <= {w_nxt_lba, w_nxt_idx};
            r_mem_rd    <= w_nxt_mem_rd;
            r_mem_wr    <= w_nxt_mem_wr;
            r_mem_din   <= w_nxt_mem_din;
        end
    end

    assign bus.sd_ack       = r_ack;
    assign bus.busy         = r_busy;
    assign bus.range_err    = r_range_err;
    assign bus.sd_buff_addr = r_buff_addr;
    assign bus.sd_buff_dout = r_buff_dout;
    assign bus.sd_buff_wr   = r_buff_wr;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_rd       = r_mem_rd;
    assign bus.mem_wr       = r_mem_wr;
    assign bus.mem_din      = r_mem_din;

endmodule

// File: tb/tb_sd_block_responder.sv
// Randomized bench for sd_block_responder with a transfer-level reference model.
module tb_sd_block_responder;

    localparam int ADDR_W    = 25;
    localparam int ACK_DELAY = 2;
`ifdef SD_RESP_WPROT_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic clk_sys;
    logic reset;

    sd_block_responder_if #(.ADDR_W(ADDR_W)) bus ();

    sd_block_responder #(.ADDR_W(ADDR_W), .ACK_DELAY(ACK_DELAY)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] mem_img [int];
    logic [7:0] sbuf [512];
    logic [7:0] rd_seen [512];

    int exp_rd_idx[$];
    logic [7:0] exp_rd_dat[$];
    int exp_wr_addr[$];
    logic [7:0] exp_wr_dat[$];

    int rd_ops, wr_ops, ack_pulses;
    bit cur_rd, first_req;
    int busy_rise_cyc, ack_fall_cyc, last_bwr_cyc;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] mem_byte(input int a);
        if (mem_img.exists(a)) return mem_img[a];
        return 8'(a) ^ 8'hA5;
    endfunction

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    initial begin
        #1_500_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Registered dual-port buffer: data follows the address by one clock
    initial begin
        logic [8:0] a;
        bus.sd_buff_din = 8'h00;
        forever begin
            @(negedge clk_sys);
            a = bus.sd_buff_addr;
            @(posedge clk_sys);
            #1 bus.sd_buff_din = sbuf[a];
        end
    end

    // Memory responder plus per-cycle output checker
    initial begin
        bit pend, pend_wr, prev_ack, prev_busy;
        int pend_wait, e_idx, e_addr;
        logic [ADDR_W-1:0] pend_addr;
        logic [7:0] pend_din, e_dat;
        pend = 0; pend_wr = 0; pend_wait = 0; pend_addr = '0; pend_din = '0;
        prev_ack = 0; prev_busy = 0;
        bus.mem_ready = 1'b0;
        bus.mem_dout  = 8'h00;
        forever begin
            @(negedge clk_sys);
            cyc++;
            if (reset) begin
                bus.mem_ready = 1'b0;
                pend = 0; prev_ack = 0; prev_busy = 0;
                continue;
            end
            if (bus.mem_ready) begin
                bus.mem_ready = 1'b0;
                check("req_gap", {bus.mem_rd, bus.mem_wr}, 2'b00);
            end else if (bus.mem_rd || bus.mem_wr) begin
                check("req_excl", {bus.mem_rd, bus.mem_wr} == 2'b11, 0);
                if (!pend) begin
                    pend = 1; pend_wr = bus.mem_wr; pend_addr = bus.mem_addr; pend_din = bus.mem_din;
                    pend_wait = $urandom_range(0, 1);
                    if (first_req) begin
                        first_req = 0;
                        check("first_access", cyc - busy_rise_cyc, bus.mem_wr ? ACK_DELAY + 2 : ACK_DELAY);
                    end
                end else begin
                    check("req_stable", {bus.mem_wr, bus.mem_addr, bus.mem_din}, {pend_wr, pend_addr, pend_din});
                end
                if (pend_wait == 0) begin
                    pend = 0;
                    bus.mem_ready = 1'b1;
                    if (pend_wr) begin
                        wr_ops++;
                        if (exp_wr_addr.size() == 0) begin
                            n_checks++; n_fail++;
                            $display("FAIL unexpected_mem_wr: actual addr=%0h, required no write", pend_addr);
                        end else begin
                            e_addr = exp_wr_addr.pop_front();
                            e_dat  = exp_wr_dat.pop_front();
                            check("mem_wr_addr", pend_addr, e_addr);
                            check("mem_wr_data", pend_din, e_dat);
                        end
                        mem_img[int'(pend_addr)] = pend_din;
                    end else begin
                        rd_ops++;
                        bus.mem_dout = mem_byte(int'(pend_addr));
                    end
                end else begin
                    pend_wait--;
                end
            end
            if (bus.sd_buff_wr) begin
                last_bwr_cyc = cyc;
                rd_seen[bus.sd_buff_addr] = bus.sd_buff_dout;
                if (exp_rd_idx.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_buff_wr: actual addr=%0h, required no strobe", bus.sd_buff_addr);
                end else begin
                    e_idx = exp_rd_idx.pop_front();
                    e_dat = exp_rd_dat.pop_front();
                    check("buff_addr", bus.sd_buff_addr, e_idx);
                    check("buff_data", bus.sd_buff_dout, e_dat);
                end
            end
            if (bus.busy && !prev_busy) busy_rise_cyc = cyc;
            if (bus.sd_ack && !prev_ack) begin
                ack_pulses++;
                check("ack_rise", cyc - busy_rise_cyc, 1);
            end
            if (!bus.sd_ack && prev_ack) begin
                ack_fall_cyc = cyc;
                check("busy_at_ack_fall", bus.busy, 1);
                if (cur_rd) check("ack_after_last", cyc - last_bwr_cyc, 1);
            end
            if (!bus.busy && prev_busy) check("busy_fall", cyc - ack_fall_cyc, 1);
            prev_ack  = bus.sd_ack;
            prev_busy = bus.busy;
        end
    end

    task automatic run_xfer(input bit wr, input bit both, input int lba, input int img,
                            input bit reraise, input bit drop_early, input int abort_at);
        bit rd_req, in_rng;
        int bound, base;
        rd_req = !wr || both;
        in_rng = (lba < img);
        base   = (lba * 512) & ((1 << ADDR_W) - 1);
        exp_rd_idx.delete(); exp_rd_dat.delete(); exp_wr_addr.delete(); exp_wr_dat.delete();
        rd_ops = 0; wr_ops = 0; ack_pulses = 0; first_req = 1; cur_rd = rd_req;
        for (int i = 0; i < 512; i++) begin
            if (rd_req) begin
                exp_rd_idx.push_back(i);
                exp_rd_dat.push_back(in_rng ? mem_byte(base + i) : 8'h00);
            end else if (in_rng && !WP) begin
                exp_wr_addr.push_back(base + i);
                exp_wr_dat.push_back(sbuf[i]);
            end
        end
        bus.sd_lba     = 32'(lba);
        bus.img_blocks = 32'(img);
        @(negedge clk_sys);
        bus.sd_rd = rd_req;
        bus.sd_wr = wr || both;
        bound = 0;
        while (!bus.busy && bound < 4) begin @(negedge clk_sys); bound++; end
        check("accept", bus.busy, 1);
        if (reraise) begin
            repeat (3) @(negedge clk_sys);
            bus.sd_rd = 1'b0;
            repeat (2) @(negedge clk_sys);
            bus.sd_rd = 1'b1;
        end else if (drop_early) begin
            bus.sd_rd = 1'b0;
            bus.sd_wr = 1'b0;
        end
        if (abort_at >= 0) begin
            bound = 0;
            while (!(bus.busy && bus.sd_buff_addr == 9'(abort_at) && (bus.mem_wr || WP)) && bound < 4000) begin
                @(negedge clk_sys); bound++;
            end
            check("abort_reach", bus.sd_buff_addr, abort_at);
            #2 reset = 1'b1;
            #1;
            check("rst_ack", bus.sd_ack, 0);
            check("rst_mem_wr", bus.mem_wr, 0);
            check("rst_mem_rd", bus.mem_rd, 0);
            check("rst_busy", bus.busy, 0);
            exp_rd_idx.delete(); exp_rd_dat.delete(); exp_wr_addr.delete(); exp_wr_dat.delete();
            bus.sd_rd = 1'b0;
            bus.sd_wr = 1'b0;
            repeat (2) @(negedge clk_sys);
            reset = 1'b0;
            @(negedge clk_sys);
            return;
        end
        bound = 0;
        while (bus.busy && bound < 6000) begin @(negedge clk_sys); bound++; end
        check("done_timeout", bus.busy, 0);
        repeat (3) begin
            @(negedge clk_sys);
            check("stay_idle", bus.busy, 0);
        end
        check("rd_left", exp_rd_idx.size(), 0);
        check("wr_left", exp_wr_addr.size(), 0);
        check("mem_rd_ops", rd_ops, (rd_req && in_rng) ? 512 : 0);
        check("mem_wr_ops", wr_ops, (!rd_req && in_rng && !WP) ? 512 : 0);
        check("ack_pulses", ack_pulses, 1);
        check("range_err", bus.range_err, !in_rng);
`ifdef SD_RESP_WPROT_EN
        if (!rd_req) check("wp_hit", bus.wp_hit, 1);
`endif
        bus.sd_rd = 1'b0;
        bus.sd_wr = 1'b0;
        repeat (2) @(negedge clk_sys);
    endtask

    initial begin
        bit wr, both;
        reset = 1'b1;
        bus.sd_lba = '0; bus.sd_rd = 1'b0; bus.sd_wr = 1'b0; bus.img_blocks = 32'd4;
        for (int i = 0; i < 512; i++) sbuf[i] = 8'h00;
        repeat (3) @(negedge clk_sys);
        check("rst_outputs", {bus.sd_ack, bus.busy, bus.range_err, bus.mem_rd, bus.mem_wr, bus.sd_buff_wr},
              6'b0);
        check("rst_buses", {bus.sd_buff_addr, bus.sd_buff_dout, bus.mem_addr, bus.mem_din}, 0);
        reset = 1'b0;
        @(negedge clk_sys);

        // In-range read from the pattern image
        run_xfer(0, 0, 2, 4, 0, 0, -1);
        check("pin_rd_0", rd_seen[0], 8'hA5);
        check("pin_rd_1", rd_seen[1], 8'hA4);
        check("pin_rd_511", rd_seen[511], 8'h5A);

        // Write with inverted-index buffer, request dropped early
        for (int i = 0; i < 512; i++) sbuf[i] = ~8'(i);
        run_xfer(1, 0, 1, 4, 0, 1, -1);
`ifdef SD_RESP_WPROT_EN
        check("pin_wp_200", mem_byte(32'h200), 8'hA5);
`else
        check("pin_wr_200", mem_byte(32'h200), 8'hFF);
        check("pin_wr_2ab", mem_byte(32'h2AB), 8'h54);
        check("pin_wr_3ff", mem_byte(32'h3FF), 8'h00);
`endif

        // Out-of-range read then an in-range read clearing range_err
        run_xfer(0, 0, 7, 4, 0, 0, -1);
        check("pin_oor_300", rd_seen[300], 8'h00);
        run_xfer(0, 0, 0, 4, 0, 0, -1);

        // Simultaneous edges plus a re-raised sd_rd during busy
        run_xfer(0, 1, 3, 4, 1, 0, -1);

        // Reset in the middle of a write, then a clean restart
        for (int i = 0; i < 512; i++) sbuf[i] = 8'($urandom);
        run_xfer(1, 0, 2, 4, 0, 0, 100);
        run_xfer(1, 0, 2, 4, 0, 0, -1);

        // Write to block 0
        run_xfer(1, 0, 0, 4, 0, 0, -1);

        // Randomized transfers, including empty images and out-of-range blocks
        for (int t = 0; t < 8; t++) begin
            wr   = 1'($urandom_range(0, 1));
            both = ($urandom_range(0, 5) == 0);
            for (int i = 0; i < 512; i++) sbuf[i] = 8'($urandom);
            run_xfer(wr, both, $urandom_range(0, 6), $urandom_range(0, 6),
                     (!wr || both) && ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
